// File: rtl/mem_burst_access_pkg.sv
// Shared definitions for the burst memory access block: FSM states, direction constants, beat clamp.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mem_burst_access_pkg;

    // Controller states: waiting for a request, driving bus beats, one-cycle completion.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Polarity of the w_rd request input.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Effective beat count: a zero request still moves one beat, oversize requests saturate.
    function automatic int clamp_beats(input int req_beats, input int max_beats);
        int n;
        n = req_beats;
        if (n < 1) begin
            n = 1;
        end else if (n > max_beats) begin
            n = max_beats;
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_burst_access_wait_timer.sv
// Per-beat wait counter: counts enabled cycles and flags expiry on the WAIT_MAX-th one.
// Latency: o_expire is combinational on the cycle that would be the WAIT_MAX-th enabled cycle.
// Backpressure: none; i_clr has priority over i_en.
module wait_timer
    import mem_burst_access_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(WAIT_MAX - 1));
    assign o_expire   = i_en && !i_clr && w_at_limit;

    // Count consecutive enabled cycles; a clear restarts the count for the next beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_burst_access.sv
// Burst memory access controller: latches a request, runs 1..MAX_BEATS bus beats, pulses done.
// Latency: N beats with zero wait states take N ACCESS cycles; done is high in the following cycle.
// Backpressure: bus_ready stalls each beat; WAIT_MAX stalled cycles abort the burst with timeout.
module mem_burst_access
    import mem_burst_access_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic                          w_rd,
    input  logic                          pc_data,
    input  logic [ADDR_W-1:0]             address,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [$clog2(MAX_BEATS):0]    beats,
    input  logic [DATA_W*MAX_BEATS-1:0]   wdata,
    input  logic [DATA_W-1:0]             bus_din,
    input  logic                          bus_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout,
    output logic [DATA_W*MAX_BEATS-1:0]   rdata,
    output logic [ADDR_W-1:0]             address_out,
    output logic [DATA_W-1:0]             bus_dout,
    output logic                          bus_oe,
    output logic                          bus_rd,
    output logic                          bus_wr
);

    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    state_t                        r_state;
    state_t                        w_next_state;

    logic                          r_w_rd;
    logic [ADDR_W-1:0]             r_addr;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_last_idx;
    logic [DATA_W*MAX_BEATS-1:0]   r_wdata;
    logic [DATA_W*MAX_BEATS-1:0]   r_rdata;
    logic                          r_timeout;

    logic                          w_accept;
    logic                          w_in_access;
    logic                          w_beat_done;
    logic                          w_last_beat;
    logic                          w_expire;
    logic                          w_timer_clr;
    logic                          w_timer_en;
    logic [ADDR_W-1:0]             w_start;
    logic [IDX_W-1:0]              w_last_idx_in;
    logic [DATA_W-1:0]             w_wr_slice;

    assign w_in_access   = (r_state == ST_ACCESS);
    assign w_accept      = (r_state == ST_IDLE) && req;
    assign w_beat_done   = w_in_access && bus_ready;
    assign w_last_beat   = (r_idx == r_last_idx);
    assign w_start       = pc_data ? pc : address;
    assign w_last_idx_in = IDX_W'(clamp_beats(int'(beats), MAX_BEATS) - 1);

    // The wait count restarts whenever a beat finishes and is held clear outside ACCESS,
    // so every beat (including the first) starts from zero.
    assign w_timer_clr   = !w_in_access || bus_ready;
    assign w_timer_en    = w_in_access && !bus_ready;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_timer_clr),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    // Select the write data slice for the current beat index.
    always_comb begin
        w_wr_slice = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_wr_slice = r_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: bus_ready wins over an expiring wait count on the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus_ready) begin
                    if (w_last_beat) begin
                        w_next_state = ST_DONE;
                    end
                end else if (w_expire) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: strobes and write drivers only while a beat is on the bus.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_oe   = 1'b0;
        bus_dout = '0;
        case (r_state)
            ST_ACCESS: begin
                busy   = 1'b1;
                bus_rd = (r_w_rd == RW_READ);
                bus_wr = (r_w_rd == RW_WRITE);
                bus_oe = (r_w_rd == RW_WRITE);
                if (r_w_rd == RW_WRITE) begin
                    bus_dout = w_wr_slice;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                timeout = r_timeout;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request latch and beat progress; the address register holds across IDLE and DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_rd     <= RW_WRITE;
            r_addr     <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_wdata    <= '0;
            r_timeout  <= 1'b0;
        end else if (w_accept) begin
            r_w_rd     <= w_rd;
            r_addr     <= w_start;
            r_idx      <= '0;
            r_last_idx <= w_last_idx_in;
            r_wdata    <= wdata;
            r_timeout  <= 1'b0;
        end else if (w_beat_done) begin
            if (!w_last_beat) begin
                r_idx  <= r_idx + IDX_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end else if (w_in_access && w_expire) begin
            r_timeout <= 1'b1;
        end
    end

    // Read data: cleared on accept, one slice captured per completed read beat, then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= '0;
        end else if (w_beat_done && (r_w_rd == RW_READ)) begin
            for (int i = 0; i < MAX_BEATS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_rdata[i*DATA_W +: DATA_W] <= bus_din;
                end
            end
        end
    end

    assign rdata       = r_rdata;
    assign address_out = r_addr;

endmodule

// File: tb/tb_mem_burst_access.sv
// Bench for mem_burst_access: directed and random bursts against a transaction-level model.
// Latency: expected done cycle derived from per-beat wait counts.
// Backpressure: bench drives bus_ready patterns, including timeouts.
module tb_mem_burst_access;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;
    localparam int WAIT_MAX  = 15;

    typedef int          wv_t [4];
    typedef logic [7:0]  dv_t [4];

    typedef struct {
        int          done_cyc;
        logic        to;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic [7:0]  dout;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        w_rd = 1'b0;
    logic        pc_data = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] pc = '0;
    logic [2:0]  beats = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  bus_din = '0;
    logic        bus_ready = 1'b0;
    logic        busy, done, timeout;
    logic [31:0] rdata;
    logic [15:0] address_out;
    logic [7:0]  bus_dout;
    logic        bus_oe, bus_rd, bus_wr;

    txn_t  txq [$];
    beat_t bq  [$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    bit    sb_on  = 1'b1;
    beat_t mb;
    txn_t  mt;

    mem_burst_access #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .w_rd(w_rd), .pc_data(pc_data),
        .address(address), .pc(pc), .beats(beats), .wdata(wdata),
        .bus_din(bus_din), .bus_ready(bus_ready), .busy(busy), .done(done),
        .timeout(timeout), .rdata(rdata), .address_out(address_out),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_rd(bus_rd), .bus_wr(bus_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares bus beats and completions against the scoreboard queues.
    always @(negedge clk) begin
        if (sb_on && rst) begin
            if (bus_rd || bus_wr) begin
                chk("busy_in_access", busy, 1);
                chk("beat_pending", bq.size() != 0, 1);
                if (bq.size() != 0) begin
                    mb = bq[0];
                    chk("beat_addr", address_out, mb.addr);
                    chk("beat_rd", bus_rd, mb.rd);
                    chk("beat_wr", bus_wr, !mb.rd);
                    chk("beat_oe", bus_oe, !mb.rd);
                    if (!mb.rd) chk("beat_dout", bus_dout, mb.dout);
                    if (bus_ready) void'(bq.pop_front());
                end
            end else begin
                chk("oe_off", bus_oe, 0);
            end
            if (done) begin
                chk("done_expected", txq.size() != 0, 1);
                if (txq.size() != 0) begin
                    mt = txq.pop_front();
                    chk("done_cycle", cyc, mt.done_cyc);
                    chk("busy_in_done", busy, 1);
                    chk("timeout_flag", timeout, mt.to);
                    chk("rdata", rdata, mt.rdata);
                    chk("leftover_beats", bq.size(), mt.to ? 1 : 0);
                end
                bq.delete();
            end else if (timeout) begin
                chk("timeout_without_done", timeout, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Operand churn while busy: the latched request must be unaffected, req must be ignored.
    task automatic scramble();
        req     = 1'($urandom);
        w_rd    = 1'($urandom);
        pc_data = 1'($urandom);
        address = 16'($urandom);
        pc      = 16'($urandom);
        beats   = 3'($urandom);
        wdata   = $urandom;
    endtask

    task automatic run_txn(input bit rd, input bit pcsel, input logic [15:0] a,
                           input logic [15:0] p, input logic [2:0] b,
                           input logic [31:0] wd, input wv_t waits, input dv_t dins);
        int          nb, t_acc;
        logic        to;
        logic [31:0] er;
        logic [15:0] start;
        beat_t       bt;
        txn_t        tx;
        nb    = (b == 0) ? 1 : ((int'(b) > MAX_BEATS) ? MAX_BEATS : int'(b));
        start = pcsel ? p : a;
        t_acc = 0;
        to    = 1'b0;
        er    = '0;
        for (int i = 0; i < nb; i++) begin
            bt.addr = start + 16'(i);
            bt.rd   = rd;
            bt.dout = rd ? 8'h00 : wd[i*8 +: 8];
            bq.push_back(bt);
            if (waits[i] >= WAIT_MAX) begin
                t_acc += WAIT_MAX;
                to = 1'b1;
                break;
            end
            t_acc += waits[i] + 1;
            if (rd) er[i*8 +: 8] = dins[i];
        end
        w_rd = rd; pc_data = pcsel; address = a; pc = p; beats = b; wdata = wd;
        req = 1'b1; bus_ready = 1'b0;
        tx.done_cyc = cyc + t_acc + 1;
        tx.to       = to;
        tx.rdata    = er;
        txq.push_back(tx);
        step();
        for (int i = 0; i < nb; i++) begin
            if (waits[i] >= WAIT_MAX) begin
                repeat (WAIT_MAX) begin
                    bus_ready = 1'b0; bus_din = 8'($urandom); scramble(); step();
                end
                break;
            end
            repeat (waits[i]) begin
                bus_ready = 1'b0; bus_din = 8'($urandom); scramble(); step();
            end
            bus_ready = 1'b1; bus_din = dins[i]; scramble(); step();
        end
        bus_ready = 1'($urandom); scramble(); step();
        req = 1'b0; bus_ready = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_bus_rd"}, bus_rd, 0);
        chk({tag, "_bus_wr"}, bus_wr, 0);
        chk({tag, "_bus_oe"}, bus_oe, 0);
        chk({tag, "_address_out"}, address_out, 0);
        chk({tag, "_bus_dout"}, bus_dout, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wv_t w0, wv;
        dv_t dv;
        int  r;
        w0 = '{0, 0, 0, 0};
        dv = '{8'hA5, 8'h3C, 8'h96, 8'h0F};

        rst = 1'b0;
        repeat (2) step();
        chk_all_zero("reset");
        rst = 1'b1;

        // Single-beat read from the pc address.
        run_txn(1, 1, 16'hBEEF, 16'h1234, 3'd1, 32'hDEADBEEF, w0, dv);
        // Four-beat zero-wait write.
        run_txn(0, 0, 16'h0200, 16'h7777, 3'd4, 32'h44332211, w0, dv);
        // Address wrap at the top of the space.
        run_txn(1, 0, 16'hFFFF, 16'h0000, 3'd2, 32'h0, w0, '{8'h11, 8'h22, 8'h0, 8'h0});
        // Three wait states per beat, no timeout.
        run_txn(1, 0, 16'h0400, 16'h0, 3'd2, 32'h0, '{3, 3, 0, 0}, '{8'hC1, 8'hC2, 8'h0, 8'h0});
        // bus_ready never arrives: timeout on the first beat.
        run_txn(1, 0, 16'h0500, 16'h0, 3'd2, 32'h0, '{15, 0, 0, 0}, dv);
        // Timeout on the second beat keeps the first slice and zeroes the rest.
        run_txn(1, 1, 16'h0, 16'h0600, 3'd4, 32'h0, '{0, 20, 0, 0}, dv);
        // bus_ready on the last allowed wait cycle still completes.
        run_txn(0, 0, 16'h0700, 16'h0, 3'd2, 32'hCAFE55AA, '{14, 0, 0, 0}, dv);
        // Beat count clamps: 0 -> 1, 7 -> MAX_BEATS.
        run_txn(1, 0, 16'h0800, 16'h0, 3'd0, 32'h0, w0, dv);
        run_txn(1, 0, 16'h0900, 16'h0, 3'd7, 32'h0, '{1, 0, 2, 0}, dv);

        // Reset during the second beat of a read.
        sb_on = 1'b0;
        w_rd = 1'b1; pc_data = 1'b0; address = 16'h0A00; beats = 3'd4; req = 1'b1;
        step();
        req = 1'b0; bus_ready = 1'b1; bus_din = 8'h5A;
        step();
        bus_ready = 1'b0;
        step();
        #2 rst = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (3) begin
            step();
            chk("midreset_no_done", done, 0);
            chk("midreset_idle", busy, 0);
        end
        rst = 1'b1;
        sb_on = 1'b1;
        run_txn(1, 0, 16'h0B00, 16'h0, 3'd3, 32'h0, w0, '{8'h01, 8'h02, 8'h03, 8'h0});

        // Random bursts.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 15);
                if (r < 10)      wv[i] = 0;
                else if (r < 13) wv[i] = $urandom_range(1, 3);
                else if (r < 15) wv[i] = $urandom_range(13, 14);
                else             wv[i] = $urandom_range(15, 18);
                dv[i] = 8'($urandom);
            end
            run_txn(1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF)) : 16'($urandom),
                    16'($urandom), 3'($urandom_range(0, 7)), $urandom, wv, dv);
        end

        repeat (5) step();
        chk("pending_txns", txq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_burst_access.md
MEM_BURST_ACCESS -- requirements
Module: mem_burst_access

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 8, bus data width; MAX_BEATS, default 4, maximum beats per request; WAIT_MAX, default 15, wait cycles per beat before timeout.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  1  request; sampled only in IDLE.
- w_rd  in  1  1 = read, 0 = write.
- pc_data  in  1  start address select; 1 = pc, 0 = address.
- address  in  ADDR_W  data start address.
- pc  in  ADDR_W  program-counter start address.
- beats  in  clog2(MAX_BEATS)+1  beat count; 0 treated as 1; values above MAX_BEATS clamp to MAX_BEATS.
- wdata  in  DATA_W*MAX_BEATS  write data; beat i = wdata[i*DATA_W +: DATA_W].
- bus_din  in  DATA_W  read data from memory.
- bus_ready  in  1  memory completes the current beat this cycle.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  one-cycle pulse, coincident with done, on abort.
- rdata  out  DATA_W*MAX_BEATS  read data; beat i in slice i.
- address_out  out  ADDR_W  bus address.
- bus_dout  out  DATA_W  write data to memory.
- bus_oe  out  1  data driver enable; high only during write beats.
- bus_rd, bus_wr  out  1  read and write strobes.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-005 In IDLE with req=1 at a rising edge, the block SHALL:
- latch w_rd, the start address (selected by pc_data), the beat count and wdata;
- clear rdata;
- enter ACCESS on the next cycle.
REQ-006 In ACCESS the block SHALL drive:
- address_out = start + beat index, wrapping modulo 2^ADDR_W (0xFFFF+1 -> 0x0000);
- bus_rd = w_rd and bus_wr = !w_rd;
- bus_oe and bus_dout (current wdata slice) for writes only.
REQ-007 A beat SHALL complete on a rising edge with bus_ready=1. On a read, bus_din SHALL be captured into rdata slice i at that edge.
REQ-008 After a beat completes, the block SHALL stay in ACCESS with the index incremented if beats remain; otherwise it SHALL go to DONE.
REQ-009 With zero wait states, an N-beat request SHALL take N ACCESS cycles. done SHALL be high in the cycle after the last beat (req edge to done = N+1 cycles).
REQ-010 Each beat SHALL have a wait counter.
- The counter SHALL clear at the start of each beat.
- If WAIT_MAX consecutive ACCESS cycles pass without bus_ready, the block SHALL go to DONE with timeout=1.
- Remaining beats SHALL be skipped; their rdata slices SHALL stay 0.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE. A req present in DONE SHALL be ignored.
REQ-012 busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.
REQ-013 req while busy SHALL be ignored. Changes to input operands after the latch SHALL have no effect.
REQ-014 In IDLE and DONE, strobes and bus_oe SHALL be 0 and address_out SHALL hold its last value.
REQ-015 rdata SHALL hold its value until the next accepted request.

Reset
REQ-016 When rst=0, the block SHALL immediately (asynchronously) enter IDLE and drive:
- busy, done, timeout, bus_rd, bus_wr, bus_oe = 0;
- address_out, bus_dout, rdata, beat index, wait counter = 0.
REQ-017 Reset asserted mid-transfer SHALL abort it with no done pulse. Operation SHALL resume on the first rising edge after rst returns to 1.

Structure
REQ-018 State encodings and the w_rd polarity constants SHALL live in the shared definitions include used by the CPU blocks.
REQ-019 The per-beat wait/timeout counter SHALL be a sub-module named wait_timer, parametrised by WAIT_MAX, with clear, count-enable and expire ports.

Verification
REQ-020 Single-beat read:
- Stimulus: pc_data=1, pc=0x1234, w_rd=1, beats=1, bus_ready=1, bus_din=0xA5.
- Response: address_out=0x1234 with bus_rd=1 for 1 cycle; done 2 cycles after req; rdata[7:0]=0xA5.
REQ-021 4-beat write:
- Stimulus: address=0x0200, wdata=0x44332211, zero wait.
- Response: address_out 0x0200..0x0203 with bus_dout 0x11, 0x22, 0x33, 0x44 and bus_oe=1; done at cycle 5.
REQ-022 Wrap:
- Stimulus: 2-beat read at 0xFFFF.
- Response: address_out 0xFFFF then 0x0000.
REQ-023 Wait states:
- Stimulus: bus_ready low 3 cycles per beat, 2-beat read.
- Response: each beat lasts 4 cycles; done at cycle 9; no timeout.
REQ-024 Timeout:
- Stimulus: bus_ready held 0.
- Response: done=timeout=1 after 15 ACCESS cycles; bus_rd drops.
REQ-025 Reset mid-beat:
- Stimulus: rst=0 during beat 2.
- Response: all outputs 0 immediately; no done; a new request after release runs normally.
